// File: rtl/sms_timing_pkg.sv
// Shared definitions for the memory-cycle timing ring: controller states
// and the default ring geometry (positions per cycle, clocks per position).
package sms_timing_pkg;

    localparam int TR_RING_LEN = 10;
    localparam int TR_DIV      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SINGLE = 2'd2
    } ring_state_e;

endpackage

// File: rtl/sms_edge_detect.sv
// Registered rising-edge detector for card-level pushbutton/step inputs.
// The previous level is held in a flop; the pulse is high during the clk
// in which the input is sampled 1 after having been sampled 0.
module sms_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_prev_r;

    // Remember the level seen at the previous clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_prev_r <= 1'b0;
        end else begin
            din_prev_r <= din;
        end
    end

    assign rise = din & ~din_prev_r;

endmodule

// File: rtl/sms_timing_ring.sv
// Memory-cycle timing ring: a one-hot ring of RING_LEN positions, each held
// for DIV master clocks. Supports continuous run, single-cycle step and a
// clean halt that always lets the current cycle finish.
module sms_timing_ring
    import sms_timing_pkg::*;
#(
    parameter int RING_LEN = TR_RING_LEN,
    parameter int DIV      = TR_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step,
    input  logic                halt,
    output logic [RING_LEN-1:0] t,
    output logic                cycle_end,
    output logic                busy,
    output logic [7:0]          cycle_cnt
);

    localparam int                    DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_PENULT = DIV_W'((DIV > 1) ? (DIV - 2) : 0);
    localparam logic [DIV_W-1:0]      DIV_INC    = DIV_W'(1);
    localparam logic                  DIV_ONE    = (DIV == 1) ? 1'b1 : 1'b0;
    localparam logic [RING_LEN-1:0]   T_FIRST    = RING_LEN'(1);

    ring_state_e         state_r;
    logic [RING_LEN-1:0] t_r;
    logic [DIV_W-1:0]    div_r;
    logic                busy_r;
    logic                cycle_end_r;
    logic [7:0]          cycle_cnt_r;

    logic                step_rise_s;
    logic                at_end_s;
    logic                pre_end_s;

    sms_edge_detect u_step_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (step),
        .rise    (step_rise_s)
    );

    // Detect the cycle boundary now (at_end_s) and one clk ahead (pre_end_s),
    // so that cycle_end can be a registered pulse aligned with the boundary.
    always_comb begin
        at_end_s = busy_r & t_r[RING_LEN-1] & (div_r == DIV_LAST);
        if (div_r == DIV_LAST) begin
            // Next clk rotates; with DIV=1 the new position is also its last clk.
            pre_end_s = busy_r & DIV_ONE & t_r[RING_LEN-2];
        end else begin
            pre_end_s = busy_r & t_r[RING_LEN-1] & (div_r == DIV_PENULT);
        end
    end

    // Ring controller: start/stop decisions, divider, ring rotation and counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            t_r         <= '0;
            div_r       <= '0;
            busy_r      <= 1'b0;
            cycle_end_r <= 1'b0;
            cycle_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    div_r       <= '0;
                    cycle_end_r <= 1'b0;
                    if (run && !halt) begin
                        state_r <= RUN;
                        t_r     <= T_FIRST;
                        busy_r  <= 1'b1;
                    end else if (step_rise_s && !halt) begin
                        state_r <= SINGLE;
                        t_r     <= T_FIRST;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        t_r     <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                RUN, SINGLE: begin
                    cycle_end_r <= pre_end_s;
                    if (at_end_s) begin
                        cycle_cnt_r <= cycle_cnt_r + 8'd1;
                        div_r       <= '0;
                        if ((state_r == RUN) && run && !halt) begin
                            // Back-to-back cycle with no idle gap.
                            t_r <= T_FIRST;
                        end else begin
                            state_r <= IDLE;
                            t_r     <= '0;
                            busy_r  <= 1'b0;
                        end
                    end else if (div_r == DIV_LAST) begin
                        div_r <= '0;
                        t_r   <= {t_r[RING_LEN-2:0], t_r[RING_LEN-1]};
                    end else begin
                        div_r <= div_r + DIV_INC;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    t_r         <= '0;
                    div_r       <= '0;
                    busy_r      <= 1'b0;
                    cycle_end_r <= 1'b0;
                end
            endcase
        end
    end

    assign t         = t_r;
    assign cycle_end = cycle_end_r;
    assign busy      = busy_r;
    assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_sms_timing_ring.sv
// Self-checking bench for sms_timing_ring: a default-geometry instance
// (10 positions x 4 clks) and a minimal one (2 x 1) share the same stimulus
// and are each compared every clock against a cycle-position model.
module tb_sms_timing_ring;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       step;
    logic       halt;

    logic [9:0] t_a;
    logic       ce_a;
    logic       busy_a;
    logic [7:0] cnt_a;
    logic [1:0] t_b;
    logic       ce_b;
    logic       busy_b;
    logic [7:0] cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sms_timing_ring #(.RING_LEN(10), .DIV(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .halt(halt),
        .t(t_a), .cycle_end(ce_a), .busy(busy_a), .cycle_cnt(cnt_a)
    );

    sms_timing_ring #(.RING_LEN(2), .DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step), .halt(halt),
        .t(t_b), .cycle_end(ce_b), .busy(busy_b), .cycle_cnt(cnt_b)
    );

    // ---------------- reference model ----------------
    // A cycle is tracked as a clk index 0..len*div-1; the active position is
    // index/div. Index 0 is reached on the edge that starts the cycle.
    bit m_act    [2];
    bit m_single [2];
    int m_idx    [2];
    int m_ccnt   [2];
    bit m_prev_step;

    function automatic int m_div(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int m_len(input int i);
        return (i == 0) ? 40 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_single[i] = 1'b0; m_idx[i] = 0; m_ccnt[i] = 0;
        end
        m_prev_step = 1'b0;
    endtask

    task automatic model_edge();
        bit rise_v, run_v, halt_v, step_v;
        if (reset_n !== 1'b1) begin
            model_reset();
        end else begin
            run_v  = (run === 1'b1);
            halt_v = (halt === 1'b1);
            step_v = (step === 1'b1);
            rise_v = step_v && !m_prev_step;
            m_prev_step = step_v;
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (run_v && !halt_v) begin
                        m_act[i] = 1'b1; m_single[i] = 1'b0; m_idx[i] = 0;
                    end else if (rise_v && !halt_v) begin
                        m_act[i] = 1'b1; m_single[i] = 1'b1; m_idx[i] = 0;
                    end
                end else if (m_idx[i] == m_len(i) - 1) begin
                    m_ccnt[i] = (m_ccnt[i] + 1) % 256;
                    if (!m_single[i] && run_v && !halt_v) m_idx[i] = 0;
                    else m_act[i] = 1'b0;
                end else begin
                    m_idx[i] = m_idx[i] + 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_t(input int i);
        logic [31:0] one;
        one = 32'd1;
        return m_act[i] ? (one << (m_idx[i] / m_div(i))) : 32'd0;
    endfunction

    function automatic logic [31:0] m_ce(input int i);
        return (m_act[i] && (m_idx[i] == m_len(i) - 1)) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic check_models();
        check("a_t",    32'(t_a),    m_t(0));
        check("a_ce",   32'(ce_a),   m_ce(0));
        check("a_busy", 32'(busy_a), 32'(m_act[0]));
        check("a_cnt",  32'(cnt_a),  32'(m_ccnt[0]));
        check("b_t",    32'(t_b),    m_t(1));
        check("b_ce",   32'(ce_b),   m_ce(1));
        check("b_busy", 32'(busy_b), 32'(m_act[1]));
        check("b_cnt",  32'(cnt_b),  32'(m_ccnt[1]));
    endtask

    // One master clock: model advances on the edge, outputs compared mid-cycle.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_models();
        end
    endtask

    // ---------------- directed vector table (default instance) ----------------
    typedef struct {
        logic       run;
        logic       step;
        logic       halt;
        int         ncyc;
        logic [9:0] exp_t;
        logic       exp_ce;
        logic       exp_busy;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0,  3, 10'h000, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,  1, 10'h001, 1'b0, 1'b1, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 39, 10'h200, 1'b1, 1'b1, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,  1, 10'h001, 1'b0, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 12, 10'h008, 1'b0, 1'b1, 8'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 27, 10'h200, 1'b1, 1'b1, 8'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1,  1, 10'h000, 1'b0, 1'b0, 8'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1,  5, 10'h000, 1'b0, 1'b0, 8'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  1, 10'h001, 1'b0, 1'b1, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0,  5, 10'h002, 1'b0, 1'b1, 8'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0,  1, 10'h002, 1'b0, 1'b1, 8'd2};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 33, 10'h200, 1'b1, 1'b1, 8'd2};
        vecs[12] = '{1'b0, 1'b1, 1'b0,  1, 10'h000, 1'b0, 1'b0, 8'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b0,  4, 10'h000, 1'b0, 1'b0, 8'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b0,  1, 10'h000, 1'b0, 1'b0, 8'd3};
        vecs[15] = '{1'b1, 1'b1, 1'b0,  1, 10'h001, 1'b0, 1'b1, 8'd3};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 40, 10'h001, 1'b0, 1'b1, 8'd4};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 40, 10'h000, 1'b0, 1'b0, 8'd5};

        reset_n = 1'b0; run = 1'b0; step = 1'b0; halt = 1'b0;
        model_reset();
        cyc(2);
        reset_n = 1'b1;

        for (int v = 0; v < 18; v++) begin
            run = vecs[v].run; step = vecs[v].step; halt = vecs[v].halt;
            cyc(vecs[v].ncyc);
            check($sformatf("vec%0d_t", v),    32'(t_a),    32'(vecs[v].exp_t));
            check($sformatf("vec%0d_ce", v),   32'(ce_a),   32'(vecs[v].exp_ce));
            check($sformatf("vec%0d_busy", v), 32'(busy_a), 32'(vecs[v].exp_busy));
            check($sformatf("vec%0d_cnt", v),  32'(cnt_a),  32'(vecs[v].exp_cnt));
        end

        // Asynchronous reset in the middle of a run, entirely between edges.
        run = 1'b1; step = 1'b0; halt = 1'b0;
        cyc(25);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_t_a",    32'(t_a),    32'd0);
        check("arst_busy_a", 32'(busy_a), 32'd0);
        check("arst_cnt_a",  32'(cnt_a),  32'd0);
        check("arst_ce_a",   32'(ce_a),   32'd0);
        check("arst_t_b",    32'(t_b),    32'd0);
        #2 reset_n = 1'b1;
        cyc(1);
        check("post_rst_t_a", 32'(t_a), 32'h001);
        check("post_rst_t_b", 32'(t_b), 32'h1);

        // Minimal ring: counter wrap after 256 completed cycles of 2 clks.
        cyc(510);
        check("wrap_255_b", 32'(cnt_b), 32'd255);
        cyc(2);
        check("wrap_0_b", 32'(cnt_b), 32'd0);

        // Randomised control activity against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(19, 0) == 0) run  = ~run;
            if ($urandom_range(29, 0) == 0) halt = ~halt;
            if ($urandom_range(3, 0) == 0)  step = ~step;
            reset_n = ($urandom_range(499, 0) == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        reset_n = 1'b1;

        // Let any cycle finish, then float step: no cycle may start.
        run = 1'b0; halt = 1'b0; step = 1'b0;
        cyc(45);
        step = 1'bz;
        cyc(6);
        check("z_busy_a", 32'(busy_a), 32'd0);
        check("z_t_a",    32'(t_a),    32'd0);
        check("z_busy_b", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
